// File: rtl/regfile_sequencer.sv
// Sequencer for a 4 x 8-bit, single-read/single-write register file: fetches two
// operands through the one read port, launches the ALU, and writes the result back.
module regfile_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [1:0] op_src_a,
  input  logic [1:0] op_src_b,
  input  logic [1:0] op_dest,
  input  logic       op_wb,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [1:0] ld_addr,
  input  logic [7:0] ld_data,
  output logic [1:0] rf_read_address,
  input  logic [7:0] rf_read_data,
  output logic [1:0] rf_write_address,
  output logic [7:0] rf_write_data,
  output logic       rf_write_enable,
  output logic       alu_start,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic       alu_done,
  input  logic [7:0] alu_result,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ_A, S_READ_B, S_EXEC, S_WB
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] src_a_q, src_a_d, src_b_q, src_b_d, dest_q, dest_d;
  logic       wb_q, wb_d;
  logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_en_q, wr_en_d;
  logic       alu_start_q, alu_start_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      src_a_q     <= 2'd0;
      src_b_q     <= 2'd0;
      dest_q      <= 2'd0;
      wb_q        <= 1'b0;
      alu_a_q     <= 8'd0;
      alu_b_q     <= 8'd0;
      wr_addr_q   <= 2'd0;
      wr_data_q   <= 8'd0;
      wr_en_q     <= 1'b0;
      alu_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      dest_q      <= dest_d;
      wb_q        <= wb_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      alu_start_q <= alu_start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    src_a_d         = src_a_q;
    src_b_d         = src_b_q;
    dest_d          = dest_q;
    wb_d            = wb_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    wr_addr_d       = wr_addr_q;
    wr_data_d       = wr_data_q;
    wr_en_d         = 1'b0;
    alu_start_d     = 1'b0;
    done_d          = 1'b0;
    err_d           = err_q;
    cnt_d           = cnt_q;
    rf_read_address = 2'd0;
    case (state_q)
      S_IDLE: begin
        // Host loads win over instructions when both are pending.
        if (ld_valid) begin
          wr_addr_d = ld_addr;
          wr_data_d = ld_data;
          wr_en_d   = 1'b1;
          state_d   = S_LOAD;
        end else if (op_valid) begin
          src_a_d = op_src_a;
          src_b_d = op_src_b;
          dest_d  = op_dest;
          wb_d    = op_wb;
          err_d   = 1'b0;
          state_d = S_READ_A;
        end
      end
      S_LOAD: state_d = S_IDLE;
      S_READ_A: begin
        rf_read_address = src_a_q;
        alu_a_d         = rf_read_data;
        state_d         = S_READ_B;
      end
      S_READ_B: begin
        rf_read_address = src_b_q;
        alu_b_d         = rf_read_data;
        alu_start_d     = 1'b1;
        cnt_d           = 8'd0;
        state_d         = S_EXEC;
      end
      S_EXEC: begin
        // A result arriving in the limit cycle still completes the instruction.
        if (alu_done) begin
          wr_addr_d = dest_q;
          wr_data_d = alu_result;
          wr_en_d   = wb_q;
          done_d    = 1'b1;
          state_d   = S_WB;
        end else if ((TO_LIM != 8'd0) && ((cnt_q + 8'd1) == TO_LIM)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign op_ready         = (state_q == S_IDLE) && !ld_valid && !reset;
  assign ld_ready         = (state_q == S_IDLE) && !reset;
  assign busy             = (state_q != S_IDLE);
  assign rf_write_address = wr_addr_q;
  assign rf_write_data    = wr_data_q;
  assign rf_write_enable  = wr_en_q;
  assign alu_start        = alu_start_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign done             = done_q;
  assign timeout_err      = err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register file and ALU responder around the DUT,
// a transaction-level reference model, directed scenarios and random traffic.
module tb_regfile_sequencer;
  localparam int TO = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       op_valid, op_ready, op_wb;
  logic [1:0] op_src_a, op_src_b, op_dest;
  logic       ld_valid, ld_ready;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [1:0] rf_read_address, rf_write_address;
  logic [7:0] rf_read_data, rf_write_data;
  logic       rf_write_enable, alu_start, alu_done;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       busy, done, timeout_err;

  always #5 clk = ~clk;

  regfile_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_src_a(op_src_a), .op_src_b(op_src_b),
    .op_dest(op_dest), .op_wb(op_wb),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .rf_read_address(rf_read_address), .rf_read_data(rf_read_data),
    .rf_write_address(rf_write_address), .rf_write_data(rf_write_data),
    .rf_write_enable(rf_write_enable),
    .alu_start(alu_start), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  // Register file with its own reset
  logic [7:0] rf [4];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (rf_write_enable) begin
      rf[rf_write_address] <= rf_write_data;
    end
  end
  assign rf_read_data = rf[rf_read_address];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // ALU responder state
  int         alu_cnt = -1;
  int         cur_k = 0;
  logic [7:0] cur_res = 8'h00;
  int         force_k = -1;
  int         force_res = -1;

  // Reference model
  typedef enum {K_IDLE, K_LOAD, K_OP, K_WB} kind_t;
  kind_t      kind;
  int         off;
  logic [1:0] sa, sb, dst;
  logic       wbf;
  logic [7:0] m_rf [4];
  logic [1:0] e_rd, e_wa;
  logic [7:0] e_wd, e_a, e_b;
  logic       e_we, e_start, e_done, e_err;
  logic       acc_ld, acc_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    kind = K_IDLE; off = 0;
    e_rd = 2'd0; e_wa = 2'd0; e_wd = 8'd0; e_a = 8'd0; e_b = 8'd0;
    e_we = 1'b0; e_start = 1'b0; e_done = 1'b0; e_err = 1'b0;
    acc_ld = 1'b0; acc_op = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
  endtask

  // Advance the model across the clock edge that ends the current cycle.
  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    acc_ld = 1'b0; acc_op = 1'b0;
    if (e_we) m_rf[e_wa] = e_wd;
    e_we = 1'b0; e_start = 1'b0; e_done = 1'b0;
    case (kind)
      K_IDLE: begin
        if (ld_valid) begin
          kind = K_LOAD; e_we = 1'b1; e_wa = ld_addr; e_wd = ld_data; acc_ld = 1'b1;
        end else if (op_valid) begin
          kind = K_OP; off = 1; sa = op_src_a; sb = op_src_b; dst = op_dest; wbf = op_wb;
          e_err = 1'b0; e_rd = op_src_a; acc_op = 1'b1;
        end
      end
      K_LOAD: kind = K_IDLE;
      K_OP: begin
        if (off == 1) begin
          e_a = m_rf[sa]; e_rd = sb;
        end else if (off == 2) begin
          e_b = m_rf[sb]; e_rd = 2'd0; e_start = 1'b1;
        end else if (alu_done) begin
          e_we = wbf; e_wa = dst; e_wd = alu_result; e_done = 1'b1; kind = K_WB;
        end else if (TO != 0 && (off - 3 + 1) == TO) begin
          e_err = 1'b1; kind = K_IDLE;
        end
        off++;
      end
      K_WB: kind = K_IDLE;
      default: kind = K_IDLE;
    endcase
  endtask

  task automatic compare();
    logic idle;
    idle = (kind == K_IDLE);
    chk("busy", 32'(busy), 32'(!idle));
    chk("ld_ready", 32'(ld_ready), 32'(idle && !reset));
    chk("op_ready", 32'(op_ready), 32'(idle && !ld_valid && !reset));
    chk("rf_read_address", 32'(rf_read_address), 32'(e_rd));
    chk("rf_write_enable", 32'(rf_write_enable), 32'(e_we));
    if (e_we) begin
      chk("rf_write_address", 32'(rf_write_address), 32'(e_wa));
      chk("rf_write_data", 32'(rf_write_data), 32'(e_wd));
    end
    chk("alu_start", 32'(alu_start), 32'(e_start));
    chk("done", 32'(done), 32'(e_done));
    chk("timeout_err", 32'(timeout_err), 32'(e_err));
    chk("alu_a", 32'(alu_a), 32'(e_a));
    chk("alu_b", 32'(alu_b), 32'(e_b));
  endtask

  // One clock cycle: ALU responds, outputs compared, model advanced.
  task automatic step();
    if (reset) begin
      alu_cnt = -1;
    end else if (alu_start === 1'b1) begin
      alu_cnt = 0;
      cur_k   = (force_k >= 0) ? force_k : int'($urandom_range(0, TO + 1));
      cur_res = (force_res >= 0) ? 8'(force_res) : 8'($urandom);
    end else if (alu_cnt >= 0) begin
      alu_cnt++;
    end
    alu_done   = (alu_cnt >= 0) && (alu_cnt == cur_k);
    alu_result = alu_done ? cur_res : 8'($urandom);
    if (alu_done) alu_cnt = -1;
    #1;
    compare();
    model_edge();
    @(negedge clk);
    cyc++;
  endtask

  task automatic issue_op(input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                          input logic w, output int t0);
    op_src_a = a; op_src_b = b; op_dest = d; op_wb = w; op_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (acc_op) break;
    end
    checks++;
    if (!acc_op) begin
      failures++;
      $display("FAIL op_accept cycle=%0d got=not_accepted expected=accepted", cyc);
    end
    op_valid = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (kind != K_IDLE && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (kind != K_IDLE) begin
      failures++;
      $display("FAIL wait_idle cycle=%0d got=busy expected=idle", cyc);
    end
  endtask

  initial begin
    int t0, starts, saw_we, saw_done;
    reset = 1'b1; op_valid = 1'b0; ld_valid = 1'b0;
    op_src_a = 2'd0; op_src_b = 2'd0; op_dest = 2'd0; op_wb = 1'b0;
    ld_addr = 2'd0; ld_data = 8'd0; alu_done = 1'b0; alu_result = 8'd0;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ld_ready", 32'(ld_ready), 32'd0);
    chk("reset_op_ready", 32'(op_ready), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Load R2 = 0x5A, then R3 = R2 op R2 with an immediate ALU
    ld_addr = 2'd2; ld_data = 8'h5A; ld_valid = 1'b1;
    step();
    ld_valid = 1'b0;
    chk("t1_load_we", 32'(rf_write_enable), 32'd1);
    chk("t1_load_addr", 32'(rf_write_address), 32'd2);
    chk("t1_load_data", 32'(rf_write_data), 32'h5A);
    step();
    chk("t1_load_we_once", 32'(rf_write_enable), 32'd0);
    force_k = 0; force_res = 8'hB4;
    issue_op(2'd2, 2'd2, 2'd3, 1'b1, t0);
    step(); step();
    chk("t1_alu_a", 32'(alu_a), 32'h5A);
    chk("t1_alu_b", 32'(alu_b), 32'h5A);
    chk("t1_alu_start", 32'(alu_start), 32'd1);
    step();
    chk("t1_wb_we", 32'(rf_write_enable), 32'd1);
    chk("t1_wb_addr", 32'(rf_write_address), 32'd3);
    chk("t1_wb_data", 32'(rf_write_data), 32'hB4);
    chk("t1_wb_done", 32'(done), 32'd1);
    step();
    chk("t1_op_ready_c5", 32'(op_ready), 32'd1);

    // Slow ALU: WB in cycle 9, ready in cycle 10
    force_k = 5; force_res = 8'h3C;
    issue_op(2'd3, 2'd2, 2'd0, 1'b1, t0);
    starts = 0;
    while (cyc - t0 < 9) begin
      if (alu_start) starts++;
      step();
    end
    chk("t2_start_pulses", 32'(starts), 32'd1);
    chk("t2_wb_done_c9", 32'(done), 32'd1);
    chk("t2_wb_data", 32'(rf_write_data), 32'h3C);
    step();
    chk("t2_op_ready_c10", 32'(op_ready), 32'd1);

    // Load and op requested together: load first, op right after LOAD
    ld_addr = 2'd1; ld_data = 8'hC3; ld_valid = 1'b1;
    op_src_a = 2'd1; op_src_b = 2'd0; op_dest = 2'd2; op_wb = 1'b1; op_valid = 1'b1;
    force_k = 1; force_res = 8'h11;
    #1;
    chk("t3_op_ready_blocked", 32'(op_ready), 32'd0);
    chk("t3_ld_ready", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0;
    chk("t3_load_we", 32'(rf_write_enable), 32'd1);
    chk("t3_load_addr", 32'(rf_write_address), 32'd1);
    step();
    chk("t3_op_ready_after_load", 32'(op_ready), 32'd1);
    step();
    op_valid = 1'b0;
    chk("t3_op_accepted", 32'(busy), 32'd1);
    chk("t3_read_a", 32'(rf_read_address), 32'd1);
    wait_idle();

    // ALU never answers: timeout after TO EXEC cycles
    force_k = 255; force_res = -1;
    issue_op(2'd3, 2'd0, 2'd1, 1'b1, t0);
    saw_we = 0; saw_done = 0;
    while (cyc - t0 < 3 + TO) begin
      if (rf_write_enable) saw_we++;
      if (done) saw_done++;
      step();
    end
    chk("t4_idle_after_timeout", 32'(busy), 32'd0);
    chk("t4_timeout_err", 32'(timeout_err), 32'd1);
    chk("t4_no_write", 32'(saw_we), 32'd0);
    chk("t4_no_done", 32'(saw_done), 32'd0);
    force_k = 0;
    issue_op(2'd0, 2'd0, 2'd0, 1'b0, t0);
    chk("t4_err_cleared", 32'(timeout_err), 32'd0);
    wait_idle();

    // Discarded result
    force_k = 2; force_res = 8'hFF;
    issue_op(2'd1, 2'd1, 2'd2, 1'b0, t0);
    while (cyc - t0 < 6) step();
    chk("t5_done", 32'(done), 32'd1);
    chk("t5_no_we", 32'(rf_write_enable), 32'd0);
    step();

    // Reset in the middle of EXEC
    force_k = 255;
    issue_op(2'd2, 2'd3, 2'd0, 1'b1, t0);
    while (cyc - t0 < 4) step();
    #2;
    reset = 1'b1;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_we", 32'(rf_write_enable), 32'd0);
    chk("t6_waddr", 32'(rf_write_address), 32'd0);
    chk("t6_wdata", 32'(rf_write_data), 32'd0);
    chk("t6_raddr", 32'(rf_read_address), 32'd0);
    chk("t6_start", 32'(alu_start), 32'd0);
    chk("t6_alu_a", 32'(alu_a), 32'd0);
    chk("t6_alu_b", 32'(alu_b), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_err", 32'(timeout_err), 32'd0);
    chk("t6_op_ready", 32'(op_ready), 32'd0);
    chk("t6_ld_ready", 32'(ld_ready), 32'd0);
    model_reset();
    @(negedge clk);
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Random traffic
    force_k = -1; force_res = -1;
    for (int i = 0; i < 600; i++) begin
      if (!ld_valid && $urandom_range(0, 5) == 0) begin
        ld_valid = 1'b1; ld_addr = 2'($urandom); ld_data = 8'($urandom);
      end
      if (!op_valid && $urandom_range(0, 2) == 0) begin
        op_valid = 1'b1; op_src_a = 2'($urandom); op_src_b = 2'($urandom);
        op_dest = 2'($urandom); op_wb = 1'($urandom);
      end
      step();
      if (acc_ld) ld_valid = 1'b0;
      if (acc_op) op_valid = 1'b0;
    end
    ld_valid = 1'b0; op_valid = 1'b0;
    wait_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
